// File: rtl/pipe_hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the decode stage, driven by a shift-register
// scoreboard of in-flight register writers (entry 0 = EX, the highest entry = WB).
module pipe_hazard_fwd_unit #(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_src1,
    input  logic [ADDR_W-1:0] id_src2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [ADDR_W-1:0] id_dest,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic              id_ready,
    output logic [SEL_W-1:0]  fwd_sel1,
    output logic [SEL_W-1:0]  fwd_sel2,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [DEPTH-1:0]             sb_v_q,    sb_v_d;
    logic [DEPTH-1:0]             sb_ld_q,   sb_ld_d;
    logic [DEPTH-1:0][ADDR_W-1:0] sb_dest_q, sb_dest_d;
    logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

    logic [SEL_W-1:0] sel1, sel2;
    logic             ld_haz1, ld_haz2;
    logic             stall_w, ready_w, issue;

    // Scan oldest to youngest so the lowest matching entry overwrites any older match.
    always_comb begin
        sel1    = '0;
        sel2    = '0;
        ld_haz1 = 1'b0;
        ld_haz2 = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (id_use1 && sb_v_q[k] && (sb_dest_q[k] == id_src1) && (id_src1 != '0)) begin
                sel1    = SEL_W'(k + 1);
                ld_haz1 = sb_ld_q[k] && (k < LOAD_LAT);
            end
            if (id_use2 && sb_v_q[k] && (sb_dest_q[k] == id_src2) && (id_src2 != '0)) begin
                sel2    = SEL_W'(k + 1);
                ld_haz2 = sb_ld_q[k] && (k < LOAD_LAT);
            end
        end
    end

    // Handshake: the decode instruction issues (leaves F-D) on a cycle with id_valid and
    // id_ready both high; with id_valid high and id_ready low it is held (stall) or
    // squashed (flush). Flush overrides stall.
    always_comb begin
        stall_w = id_valid && !flush && (ld_haz1 || ld_haz2);
        ready_w = id_valid && !stall_w && !flush;
        issue   = ready_w && id_we && (id_dest != '0);
    end

    // Entries advance every cycle, even while stalled; only new issue is blocked.
    always_comb begin
        sb_v_d       = '0;
        sb_ld_d      = '0;
        sb_dest_d    = '0;
        sb_v_d[0]    = issue;
        sb_ld_d[0]   = issue && id_is_load;
        sb_dest_d[0] = id_dest;
        for (int k = 1; k < DEPTH; k++) begin
            sb_v_d[k]    = sb_v_q[k-1];
            sb_ld_d[k]   = sb_ld_q[k-1];
            sb_dest_d[k] = sb_dest_q[k-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_w && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_v_q      <= '0;
            sb_ld_q     <= '0;
            sb_dest_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            sb_v_q      <= sb_v_d;
            sb_ld_q     <= sb_ld_d;
            sb_dest_q   <= sb_dest_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall     = stall_w;
    assign id_ready  = ready_w;
    assign fwd_sel1  = sel1;
    assign fwd_sel2  = sel2;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_fwd_unit.sv
// Directed bench for pipe_hazard_fwd_unit: forwarding distances, load-use stalls, flush,
// async reset and stall-counter saturation (second instance with a 3-bit counter).
module tb_pipe_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_src1 = '0, id_src2 = '0, id_dest = '0;
    logic       id_use1 = 1'b0, id_use2 = 1'b0, id_we = 1'b0, id_is_load = 1'b0;
    logic       flush = 1'b0;

    logic        stall, id_ready;
    logic [1:0]  fwd_sel1, fwd_sel2;
    logic [15:0] stall_cnt;
    logic        stall_s, id_ready_s;
    logic [1:0]  fwd_sel1_s, fwd_sel2_s;
    logic [2:0]  stall_cnt_s;

    logic [5:0] obs, obs_s;
    assign obs   = {stall, id_ready, fwd_sel1, fwd_sel2};
    assign obs_s = {stall_s, id_ready_s, fwd_sel1_s, fwd_sel2_s};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_fwd_unit u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use1(id_use1), .id_use2(id_use2), .id_dest(id_dest), .id_we(id_we),
        .id_is_load(id_is_load), .flush(flush), .stall(stall), .id_ready(id_ready),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt)
    );

    pipe_hazard_fwd_unit #(.CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use1(id_use1), .id_use2(id_use2), .id_dest(id_dest), .id_we(id_we),
        .id_is_load(id_is_load), .flush(flush), .stall(stall_s), .id_ready(id_ready_s),
        .fwd_sel1(fwd_sel1_s), .fwd_sel2(fwd_sel2_s), .stall_cnt(stall_cnt_s)
    );

    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic u1, input logic u2, input logic [4:0] d,
                         input logic we, input logic ld, input logic fl);
        @(negedge clk);
        id_valid = v; id_src1 = s1; id_src2 = s2; id_use1 = u1; id_use2 = u2;
        id_dest = d; id_we = we; id_is_load = ld; flush = fl;
        #1;
    endtask

    task automatic alu(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        drive(1'b1, s1, s2, 1'b1, 1'b1, d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic lw(input logic [4:0] d, input logic [4:0] base);
        drive(1'b1, base, 5'd0, 1'b1, 1'b0, d, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic nop();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; id_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        id_valid = 1'b1; id_src1 = 5'd3; id_src2 = 5'd4; id_use1 = 1'b1; id_use2 = 1'b1;
        id_dest = 5'd3; id_we = 1'b1; id_is_load = 1'b0; flush = 1'b0;
        #1;
        n_vec++;
        if (obs !== 6'b01_00_00) begin
            n_err++; $display("FAIL reset_outputs: got %b expected %b", obs, 6'b01_00_00);
        end
        n_vec++;
        if (stall_cnt !== 16'd0) begin
            n_err++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
        end
        flush = 1'b1;
        #1;
        n_vec++;
        if (obs !== 6'b00_00_00) begin
            n_err++; $display("FAIL reset_flush: got %b expected %b", obs, 6'b00_00_00);
        end
        @(negedge clk);
        flush = 1'b0; id_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_fwd_ex();
        do_reset();
        alu(5'd3, 5'd1, 5'd2); step();
        alu(5'd4, 5'd3, 5'd5);
        n_vec++;
        if (obs !== {1'b0, 1'b1, 2'd1, 2'd0}) begin
            n_err++; $display("FAIL fwd_ex: got %b expected %b", obs, {1'b0, 1'b1, 2'd1, 2'd0});
        end
        step();
    endtask

    task automatic test_fwd_mem_wb();
        do_reset();
        alu(5'd3, 5'd1, 5'd2); step();
        nop(); step();
        alu(5'd6, 5'd3, 5'd3);
        n_vec++;
        if (obs !== {1'b0, 1'b1, 2'd2, 2'd2}) begin
            n_err++; $display("FAIL fwd_mem: got %b expected %b", obs, {1'b0, 1'b1, 2'd2, 2'd2});
        end
        step();
        alu(5'd3, 5'd1, 5'd2); step();
        nop(); step();
        nop(); step();
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs !== {1'b0, 1'b1, 2'd3, 2'd3}) begin
            n_err++; $display("FAIL fwd_wb: got %b expected %b", obs, {1'b0, 1'b1, 2'd3, 2'd3});
        end
        step();
        alu(5'd7, 5'd3, 5'd3);
        n_vec++;
        if (obs !== {1'b0, 1'b1, 2'd0, 2'd0}) begin
            n_err++; $display("FAIL fwd_retired: got %b expected %b", obs, {1'b0, 1'b1, 2'd0, 2'd0});
        end
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        lw(5'd8, 5'd1);
        n_vec++;
        if (obs !== {1'b0, 1'b1, 2'd0, 2'd0}) begin
            n_err++; $display("FAIL lw_issue: got %b expected %b", obs, {1'b0, 1'b1, 2'd0, 2'd0});
        end
        step();
        alu(5'd9, 5'd8, 5'd1);
        n_vec++;
        if (obs !== {1'b1, 1'b0, 2'd1, 2'd0}) begin
            n_err++; $display("FAIL ld_stall1: got %b expected %b", obs, {1'b1, 1'b0, 2'd1, 2'd0});
        end
        step(); #1;
        n_vec++;
        if (obs !== {1'b1, 1'b0, 2'd2, 2'd0}) begin
            n_err++; $display("FAIL ld_stall2: got %b expected %b", obs, {1'b1, 1'b0, 2'd2, 2'd0});
        end
        step(); #1;
        n_vec++;
        if (obs !== {1'b0, 1'b1, 2'd3, 2'd0}) begin
            n_err++; $display("FAIL ld_release: got %b expected %b", obs, {1'b0, 1'b1, 2'd3, 2'd0});
        end
        n_vec++;
        if (stall_cnt !== 16'd2) begin
            n_err++; $display("FAIL ld_cnt: got %0d expected 2", stall_cnt);
        end
        step();
        lw(5'd8, 5'd1); step();
        nop(); step();
        alu(5'd9, 5'd8, 5'd1);
        n_vec++;
        if (obs !== {1'b1, 1'b0, 2'd2, 2'd0}) begin
            n_err++; $display("FAIL ld2_stall: got %b expected %b", obs, {1'b1, 1'b0, 2'd2, 2'd0});
        end
        step(); #1;
        n_vec++;
        if (obs !== {1'b0, 1'b1, 2'd3, 2'd0}) begin
            n_err++; $display("FAIL ld2_release: got %b expected %b", obs, {1'b0, 1'b1, 2'd3, 2'd0});
        end
        n_vec++;
        if (stall_cnt !== 16'd3) begin
            n_err++; $display("FAIL ld2_cnt: got %0d expected 3", stall_cnt);
        end
        step();
    endtask

    task automatic test_youngest();
        do_reset();
        alu(5'd3, 5'd1, 5'd2); step();
        alu(5'd3, 5'd1, 5'd2); step();
        alu(5'd4, 5'd3, 5'd3);
        n_vec++;
        if (obs !== {1'b0, 1'b1, 2'd1, 2'd1}) begin
            n_err++; $display("FAIL youngest: got %b expected %b", obs, {1'b0, 1'b1, 2'd1, 2'd1});
        end
        step();
        alu(5'd0, 5'd1, 5'd2); step();
        alu(5'd5, 5'd0, 5'd0);
        n_vec++;
        if (obs !== {1'b0, 1'b1, 2'd0, 2'd0}) begin
            n_err++; $display("FAIL r0_nomatch: got %b expected %b", obs, {1'b0, 1'b1, 2'd0, 2'd0});
        end
        step();
    endtask

    task automatic test_flush();
        do_reset();
        lw(5'd8, 5'd1); step();
        drive(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
        n_vec++;
        if (obs !== {1'b0, 1'b0, 2'd1, 2'd0}) begin
            n_err++; $display("FAIL flush_wins: got %b expected %b", obs, {1'b0, 1'b0, 2'd1, 2'd0});
        end
        step();
        drive(1'b1, 5'd9, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs !== {1'b1, 1'b0, 2'd0, 2'd2}) begin
            n_err++; $display("FAIL flush_bubble: got %b expected %b", obs, {1'b1, 1'b0, 2'd0, 2'd2});
        end
        step(); #1;
        n_vec++;
        if (obs !== {1'b0, 1'b1, 2'd0, 2'd3}) begin
            n_err++; $display("FAIL flush_older: got %b expected %b", obs, {1'b0, 1'b1, 2'd0, 2'd3});
        end
        n_vec++;
        if (stall_cnt !== 16'd1) begin
            n_err++; $display("FAIL flush_cnt: got %0d expected 1", stall_cnt);
        end
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        lw(5'd8, 5'd1); step();
        alu(5'd9, 5'd8, 5'd1);
        step(); #1;
        n_vec++;
        if (obs !== {1'b1, 1'b0, 2'd2, 2'd0}) begin
            n_err++; $display("FAIL arst_pre: got %b expected %b", obs, {1'b1, 1'b0, 2'd2, 2'd0});
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if (obs !== {1'b0, 1'b1, 2'd0, 2'd0}) begin
            n_err++; $display("FAIL arst_outputs: got %b expected %b", obs, {1'b0, 1'b1, 2'd0, 2'd0});
        end
        n_vec++;
        if (stall_cnt !== 16'd0) begin
            n_err++; $display("FAIL arst_cnt: got %0d expected 0", stall_cnt);
        end
        step();
        @(negedge clk);
        rst = 1'b1;
        alu(5'd9, 5'd8, 5'd1);
        n_vec++;
        if (obs !== {1'b0, 1'b1, 2'd0, 2'd0}) begin
            n_err++; $display("FAIL arst_resume: got %b expected %b", obs, {1'b0, 1'b1, 2'd0, 2'd0});
        end
        step();
        alu(5'd10, 5'd9, 5'd0);
        n_vec++;
        if (obs !== {1'b0, 1'b1, 2'd1, 2'd0}) begin
            n_err++; $display("FAIL arst_track: got %b expected %b", obs, {1'b0, 1'b1, 2'd1, 2'd0});
        end
        step();
    endtask

    task automatic test_back_to_back_stalls();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            lw(5'd8, 5'd1); step();
            alu(5'd9, 5'd8, 5'd1);
            step(); step(); step();
        end
        #1;
        n_vec++;
        if (stall_cnt !== 16'd10) begin
            n_err++; $display("FAIL b2b_cnt: got %0d expected 10", stall_cnt);
        end
        n_vec++;
        if (stall_cnt_s !== 3'd7) begin
            n_err++; $display("FAIL sat_cnt: got %0d expected 7", stall_cnt_s);
        end
        lw(5'd8, 5'd1); step();
        alu(5'd9, 5'd8, 5'd1);
        n_vec++;
        if (obs_s !== {1'b1, 1'b0, 2'd1, 2'd0}) begin
            n_err++; $display("FAIL sat_outputs: got %b expected %b", obs_s, {1'b1, 1'b0, 2'd1, 2'd0});
        end
        step(); #1;
        n_vec++;
        if (stall_cnt_s !== 3'd7) begin
            n_err++; $display("FAIL sat_hold: got %0d expected 7", stall_cnt_s);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_fwd_ex();
        test_fwd_mem_wb();
        test_load_use();
        test_youngest();
        test_flush();
        test_async_reset();
        test_back_to_back_stalls();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
